// File: rtl/uart_line_pattern_gen_if.sv
// Byte-wide valid/ready handshake between the pattern source and the UART TX core.
interface uart_line_pattern_gen_if;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_byte;

  modport master (
    output tx_valid,
    output tx_byte,
    input  tx_ready
  );

  modport slave (
    input  tx_valid,
    input  tx_byte,
    output tx_ready
  );
endinterface

// File: rtl/uart_line_pattern_gen.sv
// ASCII test-pattern source: lines of consecutive characters from START_CHAR, each
// terminated by an end-of-line sequence, in staircase or fixed-width mode.
module uart_line_pattern_gen #(
  parameter logic [7:0]  START_CHAR = 8'h30,
  parameter int unsigned SPAN       = 62,
  parameter int unsigned LINE_MODE  = 0,
  parameter int unsigned EOL_MODE   = 0,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  uart_line_pattern_gen_if.master  tx,
  output logic                     busy,
  output logic [CNT_W-1:0]         line_cnt
);

  typedef enum logic [1:0] {StIdle, StChar, StEol1, StEol2} state_e;

  localparam logic [7:0] SpanM1 = 8'(SPAN - 1);

`ifndef SYNTHESIS
  if (SPAN == 0 || SPAN > 255 || (int'(START_CHAR) + SPAN > 256) || EOL_MODE > 2)
  begin : g_param_check
    $error("uart_line_pattern_gen: illegal START_CHAR/SPAN/EOL_MODE combination");
  end
`endif

  state_e           state_q, state_d;
  logic [7:0]       col_q, col_d;
  logic [7:0]       pos_q, pos_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       last_col;
  logic             xfer;
  logic             line_end;

  assign xfer     = tx.tx_valid && tx.tx_ready;
  // Index of the final character of the current line.
  assign last_col = (LINE_MODE == 1) ? SpanM1 : pos_q;

  // State and counters; reset abandons any line in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      col_q   <= 8'h00;
      pos_q   <= 8'h00;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      pos_q   <= pos_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: advance only on a transfer; EN is honoured in idle and at line end.
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    pos_d    = pos_q;
    cnt_d    = cnt_q;
    line_end = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (en) begin
          state_d = StChar;
          col_d   = 8'h00;
        end
      end
      StChar: begin
        if (xfer) begin
          if (col_q == last_col) state_d = StEol1;
          else                   col_d   = col_q + 8'd1;
        end
      end
      StEol1: begin
        if (xfer) begin
          if (EOL_MODE == 1) state_d  = StEol2;
          else               line_end = 1'b1;
        end
      end
      StEol2: begin
        if (xfer) line_end = 1'b1;
      end
      default: state_d = StIdle;
    endcase
    if (line_end) begin
      cnt_d   = cnt_q + CNT_W'(1);
      pos_d   = (pos_q == SpanM1) ? 8'h00 : pos_q + 8'd1;
      col_d   = 8'h00;
      state_d = en ? StChar : StIdle;
    end
  end

  // Outputs decode purely from state so they hold while the sink stalls.
  always_comb begin
    tx.tx_byte = 8'h00;
    unique case (state_q)
      StIdle: tx.tx_byte = 8'h00;
      StChar: tx.tx_byte = START_CHAR + col_q;
      StEol1: tx.tx_byte = (EOL_MODE == 0) ? 8'h0A : 8'h0D;
      StEol2: tx.tx_byte = 8'h0A;
      default: tx.tx_byte = 8'h00;
    endcase
    tx.tx_valid = (state_q != StIdle);
    busy        = (state_q != StIdle);
    line_cnt    = cnt_q;
  end

endmodule

// File: tb/tb_uart_line_pattern_gen.sv
// Directed bench for uart_line_pattern_gen: default staircase, CR LF fixed-width,
// back-pressure, EN drop mid-line, async reset and line counter wrap.
module tb_uart_line_pattern_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        en0, en1, en2;
  logic        busy0, busy1, busy2;
  logic [15:0] cnt0, cnt1;
  logic [3:0]  cnt2;

  uart_line_pattern_gen_if tx0();
  uart_line_pattern_gen_if tx1();
  uart_line_pattern_gen_if tx2();

  uart_line_pattern_gen u_dut0 (
    .clk(clk), .rst(rst), .en(en0), .tx(tx0), .busy(busy0), .line_cnt(cnt0)
  );

  uart_line_pattern_gen #(.SPAN(3), .LINE_MODE(1), .EOL_MODE(1)) u_dut1 (
    .clk(clk), .rst(rst), .en(en1), .tx(tx1), .busy(busy1), .line_cnt(cnt1)
  );

  uart_line_pattern_gen #(.SPAN(1), .CNT_W(4)) u_dut2 (
    .clk(clk), .rst(rst), .en(en2), .tx(tx2), .busy(busy2), .line_cnt(cnt2)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Inputs are driven and outputs read 1 time unit after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0]  got0[$];
  logic [7:0]  got1[$];
  logic [7:0]  got2[$];
  logic [15:0] seen_cnt1[$];
  logic [3:0]  seen_cnt2[$];
  logic [7:0]  exp0[$];

  logic       stall_prev = 1'b0;
  logic [7:0] held_byte  = 8'h00;

  // Capture bytes that will transfer on the coming edge; enforce hold under stall.
  always @(negedge clk) begin
    if (stall_prev && !rst) begin
      check("hold_valid", tx0.tx_valid, 1);
      check("hold_byte", tx0.tx_byte, held_byte);
    end
    if (tx0.tx_valid && tx0.tx_ready) got0.push_back(tx0.tx_byte);
    stall_prev <= tx0.tx_valid && !tx0.tx_ready && !rst;
    held_byte  <= tx0.tx_byte;
  end

  always @(negedge clk) begin
    if (tx1.tx_valid && tx1.tx_ready) begin
      got1.push_back(tx1.tx_byte);
      seen_cnt1.push_back(cnt1);
    end
    if (tx2.tx_valid && tx2.tx_ready) begin
      got2.push_back(tx2.tx_byte);
      seen_cnt2.push_back(cnt2);
    end
  end

  task automatic wait_idle0(input string tag);
    for (int t = 0; t < 200 && busy0; t++) tick();
    check(tag, busy0, 0);
  endtask

  task automatic wait_size0(input string tag, input int n, input int budget);
    for (int t = 0; t < budget && got0.size() < n; t++) tick();
    check(tag, (got0.size() >= n) ? 1 : 0, 1);
  endtask

  logic [7:0] pat1 [5];

  initial begin
    pat1 = '{8'h30, 8'h31, 8'h32, 8'h0D, 8'h0A};
    // Reference stream for the default instance: 63 staircase lines, line k has k%62+1 chars.
    for (int k = 0; k < 63; k++) begin
      for (int c = 0; c <= k % 62; c++) exp0.push_back(8'(8'h30 + c));
      exp0.push_back(8'h0A);
    end

    rst = 1'b1;
    en0 = 1'b0; en1 = 1'b0; en2 = 1'b0;
    tx0.tx_ready = 1'b1; tx1.tx_ready = 1'b1; tx2.tx_ready = 1'b1;
    tick();
    check("rst_valid", tx0.tx_valid, 0);
    check("rst_byte", tx0.tx_byte, 8'h00);
    check("rst_busy", busy0, 0);
    check("rst_cnt", cnt0, 0);
    rst = 1'b0;
    tick();

    // CR LF fixed-width and counter wrap instances.
    en1 = 1'b1;
    en2 = 1'b1;
    for (int t = 0; t < 80; t++) begin
      tick();
      if (got1.size() >= 6) en1 = 1'b0;
      if (got2.size() >= 35) en2 = 1'b0;
    end
    check("crlf_busy", busy1, 0);
    check("crlf_len", got1.size(), 10);
    for (int i = 0; i < got1.size() && i < 10; i++) begin
      check("crlf_byte", got1[i], pat1[i % 5]);
      check("crlf_cnt", seen_cnt1[i], i / 5);
    end
    check("crlf_final_cnt", cnt1, 2);
    check("wrap_busy", busy2, 0);
    check("wrap_len", got2.size(), 36);
    for (int i = 0; i < got2.size() && i < 36; i++) begin
      check("wrap_byte", got2[i], (i % 2 == 0) ? 8'h30 : 8'h0A);
      check("wrap_cnt", seen_cnt2[i], (i / 2) % 16);
    end
    check("wrap_final_cnt", cnt2, 2);

    // Full default staircase with no back-pressure.
    en0 = 1'b1;
    tick();
    check("latency_valid", tx0.tx_valid, 1);
    for (int t = 0; t < 3000 && got0.size() < 2016; t++) begin
      tick();
      check("no_idle", tx0.tx_valid, 1);
    end
    check("stair_cnt62", cnt0, 62);
    en0 = 1'b0;
    tick();
    check("stair_busy", busy0, 0);
    check("stair_cnt63", cnt0, 63);
    check("stair_len", got0.size(), 2017);
    for (int i = 0; i < got0.size() && i < exp0.size(); i++) check("stair_byte", got0[i], exp0[i]);

    // Random back-pressure must not alter the byte sequence.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    got0.delete();
    en0 = 1'b1;
    for (int t = 0; t < 5000 && got0.size() < 300; t++) begin
      tick();
      tx0.tx_ready = ($urandom_range(0, 9) < 3);
    end
    en0 = 1'b0;
    tx0.tx_ready = 1'b1;
    wait_idle0("bp_idle");
    check("bp_len", (got0.size() >= 300) ? 1 : 0, 1);
    for (int i = 0; i < got0.size() && i < exp0.size(); i++) check("bp_byte", got0[i], exp0[i]);

    // Drop EN while '1' of line "012" is presented, then resume the staircase.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    got0.delete();
    en0 = 1'b1;
    wait_size0("en_drop_reach", 6, 50);
    check("en_drop_byte", tx0.tx_byte, 8'h31);
    en0 = 1'b0;
    wait_idle0("en_drop_idle");
    check("en_drop_valid", tx0.tx_valid, 0);
    check("en_drop_cnt", cnt0, 3);
    check("en_drop_len", got0.size(), 9);
    for (int i = 0; i < got0.size() && i < 9; i++) check("en_drop_byte_seq", got0[i], exp0[i]);
    en0 = 1'b1;
    wait_size0("resume_reach", 10, 50);
    en0 = 1'b0;
    wait_idle0("resume_idle");
    check("resume_len", got0.size(), 14);
    for (int i = 9; i < got0.size() && i < 14; i++) check("resume_byte", got0[i], exp0[i]);

    // Async reset mid-line.
    en0 = 1'b1;
    wait_size0("rst_mid_reach", 17, 50);
    check("pre_rst_valid", tx0.tx_valid, 1);
    check("pre_rst_cnt", cnt0, 4);
    rst = 1'b1;
    #1;
    check("async_valid", tx0.tx_valid, 0);
    check("async_cnt", cnt0, 0);
    check("async_busy", busy0, 0);
    tick();
    rst = 1'b0;
    got0.delete();
    wait_size0("post_rst_reach", 1, 50);
    en0 = 1'b0;
    wait_idle0("post_rst_idle");
    check("post_rst_len", got0.size(), 2);
    if (got0.size() >= 2) begin
      check("post_rst_b0", got0[0], 8'h30);
      check("post_rst_b1", got0[1], 8'h0A);
    end
    check("post_rst_cnt", cnt0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
